fsk_pcm_buffer: RTL and testbench
=================================

FSK_PCM_BUFFER -- requirements
Module: fsk_pcm_buffer

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO depth in 16-bit words; a power of two, at least 4.
REQ-002 The block SHALL have parameter PRIME_LVL, default 4, fill level required before playback starts; range 1..DEPTH.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have these ports:
- sysclk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sig_use  in  16  recovered PCM word from the FSK receive chain.
- word_valid  in  1  one-cycle strobe: sig_use holds a new word.
- dac_tick  in  1  one-cycle strobe at the 8 kHz output sample rate, synchronous to sysclk.
- clr_flags  in  1  synchronous clear of the sticky flags.
- dac_data  out  16  registered sample presented to the DAC.
- dac_load  out  1  one-cycle pulse: dac_data was updated.
- fill  out  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- playing  out  1  high in state PLAY.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow flag.

Function
REQ-004 Storage SHALL be a circular FIFO of DEPTH x 16 bits with write and read pointers that wrap modulo DEPTH.
REQ-005 A push SHALL occur on word_valid=1 when fill<DEPTH, or when fill=DEPTH and a pop occurs in the same cycle.
REQ-006 word_valid=1 with fill=DEPTH and no same-cycle pop SHALL drop the word, leave fill and the pointers unchanged, and set ovf.
REQ-007 The state machine SHALL have two states, PRIME and PLAY, and SHALL enter PRIME at reset.
REQ-008 PRIME to PLAY SHALL occur on the first rising edge at which fill>=PRIME_LVL.
REQ-009 In PRIME, dac_tick SHALL produce dac_load=1 on the next cycle with dac_data=16'h0000, and no pop.
REQ-010 In PLAY, dac_tick with fill>0 SHALL pop the head word into dac_data and assert dac_load on the next cycle (latency 1).
REQ-011 In PLAY, dac_tick with fill=0 SHALL:
- set udf;
- hold dac_data at its last value;
- pulse dac_load on the next cycle;
- return to PRIME.
REQ-012 There SHALL be no write-to-read bypass: a push and a tick in the same cycle at fill=0 SHALL count as underflow, and the pushed word SHALL still be stored.
REQ-013 Simultaneous push and pop SHALL leave fill unchanged. A push alone SHALL increment fill by 1; a pop alone SHALL decrement fill by 1.
REQ-014 clr_flags=1 SHALL clear ovf and udf on the next edge. An overflow or underflow event in the same cycle SHALL take priority and leave its flag set.
REQ-015 dac_load SHALL be exactly one cycle wide per dac_tick. Back-to-back ticks SHALL each be serviced.
REQ-016 playing SHALL equal 1 exactly when the state is PLAY.

Reset
REQ-017 While reset=0, regardless of sysclk, the block SHALL force:
- state=PRIME;
- read and write pointers=0;
- fill=0;
- dac_data=0, dac_load=0;
- ovf=0, udf=0, playing=0.
REQ-018 Reset asserted mid-operation SHALL discard FIFO contents. FIFO memory need not be cleared, but data SHALL be unreadable until rewritten.
REQ-019 After reset release, the first push and the first tick SHALL be honoured in the first cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Prime/play: push 0x1111..0x4444 (4 words), then tick. Required: playing=1 after 4th push; dac_data=0x1111 with dac_load one cycle after the tick; fill 4->3.
- Priming output: tick with fill=2. Required: dac_load=1, dac_data=0x0000, fill stays 2.
- Overflow: push 9 words 0x0001..0x0009 without ticks. Required: fill=8, ovf=1; word 0x0009 lost; drained order 0x0001..0x0008.
- Full with simultaneous push and pop: in PLAY at fill=8, push 0xAAAA together with a tick. Required: fill stays 8, ovf=0, head popped, 0xAAAA read out last.
- Underflow: in PLAY, drain to 0, then tick together with a push of 0x5A5A. Required: udf=1, dac_data holds previous value, state=PRIME, fill=1. Then clr_flags. Required: udf=0.
- Reset mid-operation: assert reset at fill=5 in PLAY. Required: outputs zero immediately, without a clock edge; after release, a tick yields dac_data=0x0000.

Source files
------------

// File: rtl/fsk_pcm_buffer.sv
// Jitter buffer between the FSK receive chain and an 8 kHz DAC: a circular
// FIFO of PCM words, primed to PRIME_LVL before playback, with sticky flags.
module fsk_pcm_buffer #(
  parameter int DEPTH     = 8,
  parameter int PRIME_LVL = 4
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic [15:0]              sig_use,
  input  logic                     word_valid,
  input  logic                     dac_tick,
  input  logic                     clr_flags,
  output logic [15:0]              dac_data,
  output logic                     dac_load,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     playing,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  typedef enum logic {
    PRIME = 1'b0,
    PLAY  = 1'b1
  } state_e;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  state_e        state_q, state_d;
  logic [15:0]   dac_data_q, dac_data_d;
  logic          dac_load_q, dac_load_d;
  logic          playing_q, playing_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          full_s, empty_s;
  logic          pop_s, push_s;
  logic          ovf_evt_s, udf_evt_s;

  // Transfer decisions; a pop frees the slot so a full FIFO can still accept a push.
  always_comb begin
    full_s    = (fill_q == FW'(DEPTH));
    empty_s   = (fill_q == {FW{1'b0}});
    pop_s     = dac_tick && (state_q == PLAY) && !empty_s;
    udf_evt_s = dac_tick && (state_q == PLAY) && empty_s;
    push_s    = word_valid && (!full_s || pop_s);
    ovf_evt_s = word_valid && full_s && !pop_s;
  end

  // Next-state for pointers, occupancy, FSM, output sample and flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    state_d    = state_q;
    dac_data_d = dac_data_q;
    dac_load_d = dac_tick;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    case (state_q)
      PRIME: begin
        if (fill_q >= FW'(PRIME_LVL)) begin
          state_d = PLAY;
        end else begin
          state_d = PRIME;
        end
      end
      PLAY: begin
        if (udf_evt_s) begin
          state_d = PRIME;
        end else begin
          state_d = PLAY;
        end
      end
      default: state_d = PRIME;
    endcase

    // While priming the DAC gets silence; an underflow holds the last sample.
    if (dac_tick && (state_q == PRIME)) begin
      dac_data_d = 16'h0000;
    end else if (pop_s) begin
      dac_data_d = mem_q[rd_ptr_q];
    end else begin
      dac_data_d = dac_data_q;
    end

    playing_d = (state_d == PLAY);

    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (clr_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (udf_evt_s) begin
      udf_d = 1'b1;
    end else if (clr_flags) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      fill_q     <= {FW{1'b0}};
      state_q    <= PRIME;
      dac_data_q <= 16'h0000;
      dac_load_q <= 1'b0;
      playing_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
      dac_data_q <= dac_data_d;
      dac_load_q <= dac_load_d;
      playing_q  <= playing_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Sample storage; stale words are unreachable after reset because fill restarts at 0.
  always_ff @(posedge sysclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= sig_use;
    end
  end

  assign dac_data = dac_data_q;
  assign dac_load = dac_load_q;
  assign fill     = fill_q;
  assign playing  = playing_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_fsk_pcm_buffer.sv
// Directed and random checks of fsk_pcm_buffer against a queue-based model.
module tb_fsk_pcm_buffer;

  localparam int DEPTH     = 8;
  localparam int PRIME_LVL = 4;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sig_use = 16'h0000;
  logic        word_valid = 1'b0;
  logic        dac_tick = 1'b0;
  logic        clr_flags = 1'b0;
  logic [15:0] dac_data;
  logic        dac_load;
  logic [3:0]  fill;
  logic        playing;
  logic        ovf;
  logic        udf;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  bit          m_play = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;
  bit          m_load = 1'b0;
  logic [15:0] m_data = 16'h0000;

  fsk_pcm_buffer #(.DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
    .sysclk(sysclk), .reset(reset), .sig_use(sig_use), .word_valid(word_valid),
    .dac_tick(dac_tick), .clr_flags(clr_flags), .dac_data(dac_data),
    .dac_load(dac_load), .fill(fill), .playing(playing), .ovf(ovf), .udf(udf)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_model();
    chk("fill",     32'(fill),     32'(mq.size()));
    chk("playing",  32'(playing),  32'(m_play));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    chk("udf",      32'(udf),      32'(m_udf));
    chk("dac_load", 32'(dac_load), 32'(m_load));
    chk("dac_data", 32'(dac_data), 32'(m_data));
  endtask

  // One clock of stimulus; the model advances from the pre-edge state.
  task automatic cyc(input bit wv, input logic [15:0] d, input bit tk, input bit clr);
    int n;
    bit pop, und, ov, nplay;
    logic [15:0] ndata;
    @(negedge sysclk);
    word_valid = wv; sig_use = d; dac_tick = tk; clr_flags = clr;
    n     = mq.size();
    pop   = tk && m_play && (n > 0);
    und   = tk && m_play && (n == 0);
    ov    = wv && (n == DEPTH) && !pop;
    ndata = m_data;
    if (tk && !m_play) ndata = 16'h0000;
    else if (pop) ndata = mq[0];
    nplay = m_play ? !und : (n >= PRIME_LVL);
    @(posedge sysclk);
    if (pop) void'(mq.pop_front());
    if (wv && !ov) mq.push_back(d);
    m_ovf  = ov  ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf  = und ? 1'b1 : (clr ? 1'b0 : m_udf);
    m_play = nplay;
    m_data = ndata;
    m_load = tk;
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    word_valid = 1'b0; dac_tick = 1'b0; clr_flags = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_dac_data", 32'(dac_data), 32'h0);
    chk("rst_dac_load", 32'(dac_load), 32'h0);
    chk("rst_fill",     32'(fill),     32'h0);
    chk("rst_playing",  32'(playing),  32'h0);
    chk("rst_ovf",      32'(ovf),      32'h0);
    chk("rst_udf",      32'(udf),      32'h0);
    mq.delete();
    m_play = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_load = 1'b0; m_data = 16'h0000;
    @(negedge sysclk);
    reset = 1'b1;
  endtask

  initial begin
    #12;
    chk("init_fill",    32'(fill),     32'h0);
    chk("init_playing", 32'(playing),  32'h0);
    chk("init_data",    32'(dac_data), 32'h0);
    chk("init_load",    32'(dac_load), 32'h0);
    @(negedge sysclk);
    reset = 1'b1;

    // Prime then play
    cyc(1'b1, 16'h1111, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0);
    cyc(1'b1, 16'h3333, 1'b0, 1'b0);
    cyc(1'b1, 16'h4444, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("play_after_prime", 32'(playing), 32'h1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("first_pop_data", 32'(dac_data), 32'h1111);
    chk("first_pop_load", 32'(dac_load), 32'h1);
    chk("first_pop_fill", 32'(fill),     32'h3);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("load_one_cycle", 32'(dac_load), 32'h0);

    // Drain, then underflow with a simultaneous push
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b1, 16'h5A5A, 1'b1, 1'b0);
    chk("udf_set",     32'(udf),      32'h1);
    chk("udf_hold",    32'(dac_data), 32'h4444);
    chk("udf_state",   32'(playing),  32'h0);
    chk("udf_fill",    32'(fill),     32'h1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("udf_cleared", 32'(udf),      32'h0);

    // Priming output at fill=2
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("prime_load", 32'(dac_load), 32'h1);
    chk("prime_data", 32'(dac_data), 32'h0);
    chk("prime_fill", 32'(fill),     32'h2);

    // Reach fill=5 in PLAY, then reset without a clock edge
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    chk("pre_rst_play", 32'(playing), 32'h1);
    chk("pre_rst_fill", 32'(fill),    32'h5);
    do_reset();
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("post_rst_data", 32'(dac_data), 32'h0);
    chk("post_rst_load", 32'(dac_load), 32'h1);

    // Overflow: ninth word dropped
    for (int i = 1; i <= 9; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    chk("ovf_fill", 32'(fill), 32'h8);
    chk("ovf_flag", 32'(ovf),  32'h1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf), 32'h0);

    // Full with simultaneous push and pop
    cyc(1'b1, 16'hAAAA, 1'b1, 1'b0);
    chk("full_pp_fill", 32'(fill),     32'h8);
    chk("full_pp_ovf",  32'(ovf),      32'h0);
    chk("full_pp_data", 32'(dac_data), 32'h0001);
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("full_pp_last", 32'(dac_data), 32'hAAAA);
    chk("drained_fill", 32'(fill),     32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
